slowclock_rate_controller: RTL and testbench
============================================

Name: slowclock_rate_controller

Overview:
- Run/pause/single-step controller for the board slow-clock divider.
- Selects one of four divider half-periods from the switches and applies a new rate only at a period boundary, so there are no runt pulses.
- Drives the slowclock square wave and a one-cycle tick for the LED/7-seg animation logic.
- Sits between the switch/button debouncers and the display datapath, on the 100 MHz board clock.

Parameters:
- CNT_W, 26: counter width; every HALFn must fit in it.
- HALF0, 67_108_863: terminal count for rate 0 (about 0.745 Hz at 100 MHz).
- HALF1, 33_554_431: terminal count for rate 1 (about 1.49 Hz).
- HALF2, 16_777_215: terminal count for rate 2 (about 2.98 Hz).
- HALF3, 8_388_607: terminal count for rate 3 (about 5.96 Hz).

Ports:
- clock  in  1  board clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rate_sel  in  2  requested rate index; sampled only at load points.
- run  in  1  level: 1 = free-run, 0 = stop at the next period boundary.
- step  in  1  one-cycle pulse (already debounced): request one full period while stopped.
- slowclock  out  1  divided square wave, registered.
- tick  out  1  one-cycle pulse in the cycle slowclock goes 0->1.
- state  out  2  IDLE=00, PAUSE=01, RUN=10, STEP=11.
- rate_active  out  2  rate index currently in use.

Behaviour:
- Reset (async, reset_n=0): count=0, slowclock=0, tick=0, state=IDLE, rate_active=0. Outputs must hold these values for as long as reset_n is low.
- Divider rule (RUN and STEP only):
  - H = HALF[rate_active].
  - If count==H: count<=0 and slowclock toggles; otherwise count<=count+1.
  - Each half-period lasts H+1 cycles; one period is 2(H+1) cycles.
- tick: registered. It is 1 exactly in the cycle slowclock first reads 1, and 0 in all other cycles.
- Period boundary: count==H while slowclock==1, i.e. the falling toggle.
- IDLE / PAUSE:
  - count and slowclock frozen at 0/0; tick=0.
  - run=1 -> RUN next cycle; rate_active<=rate_sel; count starts from 0.
  - Otherwise step=1 -> STEP, with the same load.
  - run has priority over step.
  - IDLE and PAUSE behave identically; IDLE exists only to report "no activity since reset".
- RUN:
  - At each period boundary, if run==1: stay in RUN and rate_active<=rate_sel.
  - At each period boundary, if run==0: go to PAUSE, with slowclock=0 and count=0.
  - step is ignored.
  - run falling mid-period never truncates the period.
- STEP:
  - Runs exactly one period.
  - At the boundary: go to RUN if run==1 (rate_active reloaded), else PAUSE.
  - Further step pulses during STEP are ignored and not queued.
- Rate changes: a change of rate_sel mid-period has no effect until the next load point. First rising edge after a load is H+1 cycles later, using the new H.
- HALFn=0 is legal: slowclock toggles every cycle and tick fires every other cycle.
- Counter width: no overflow is possible because count never exceeds H < 2^CNT_W.
- rate_sel, run and step are synchronous to clock; synchronising them is the debouncers' responsibility.

Decomposition:
- Package slowclock_pkg:
  - state encodings IDLE/PAUSE/RUN/STEP;
  - default HALF0..HALF3 constants;
  - CNT_W.
- Sub-module slowclock_div_core:
  - contents: counter plus toggle register;
  - inputs: enable, clear, terminal H;
  - outputs: slowclock, tick, at_boundary.
- The controller owns only the FSM and the rate_active register.

Test Plan (bench overrides HALF0=3, HALF1=1, HALF2=0, HALF3=7):
1. Reset: hold reset_n=0 with run=1 -> slowclock=0, tick=0, state=00, rate_active=0. Deassert reset_n -> state=10 one cycle later; slowclock rises 4 cycles after entry, tick=1 for exactly that cycle; period is 8 cycles.
2. Rate change mid-run: rate_sel 0->1 two cycles after a rising edge -> current period completes at 8 cycles; rate_active=1 at the boundary; following periods are 4 cycles.
3. Pause mid-period: run dropped 1 cycle after slowclock rises -> slowclock stays high 3 more cycles, falls, state=01, no further ticks; count and slowclock frozen at 0.
4. Step in PAUSE: rate_sel=3, one step pulse -> state=11, exactly one tick after 8 cycles, one 16-cycle period, then state=01. A second step pulse mid-step produces no extra period.
5. HALF2=0 with run=1, rate_sel=2 -> slowclock toggles every cycle and tick alternates 1,0. Assert step simultaneously with run from PAUSE -> state=10, not 11.
6. Async reset mid-RUN (slowclock=1, count=2): reset_n low between clock edges -> outputs clear immediately without a clock edge, and state returns to IDLE.

Source files
------------

// File: rtl/slowclock_pkg.sv
// Shared types and default constants for the slow-clock rate controller.
// Default half-periods target the 100 MHz board clock.
package slowclock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PAUSE = 2'b01,
    RUN   = 2'b10,
    STEP  = 2'b11
  } sc_state_e;

  localparam int DEF_CNT_W = 26;
  localparam int DEF_HALF0 = 67_108_863;
  localparam int DEF_HALF1 = 33_554_431;
  localparam int DEF_HALF2 = 16_777_215;
  localparam int DEF_HALF3 = 8_388_607;

endpackage

// File: rtl/slowclock_rate_controller_if.sv
// Control/status bundle between the debouncers, the rate controller
// and the display datapath.
interface slowclock_rate_controller_if;
  import slowclock_pkg::*;

  logic [1:0] rate_sel;
  logic       run;
  logic       step;
  logic       slowclock;
  logic       tick;
  sc_state_e  state;
  logic [1:0] rate_active;

  modport master (
    output rate_sel,
    output run,
    output step,
    input  slowclock,
    input  tick,
    input  state,
    input  rate_active
  );

  modport slave (
    input  rate_sel,
    input  run,
    input  step,
    output slowclock,
    output tick,
    output state,
    output rate_active
  );

endinterface

// File: rtl/slowclock_div_core.sv
// Half-period counter plus toggle register; each half lasts h+1 cycles.
// tick is registered alongside the rising toggle.
module slowclock_div_core
  import slowclock_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] h,
  output logic             slowclock,
  output logic             tick,
  output logic             at_boundary
);

  logic [CNT_W-1:0] count;
  logic             at_term;

  assign at_term     = (count == h);
  assign at_boundary = enable && at_term && slowclock;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      slowclock <= 1'b0;
      tick      <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      slowclock <= 1'b0;
      tick      <= 1'b0;
    end else if (enable) begin
      if (at_term) begin
        count     <= '0;
        slowclock <= ~slowclock;
        tick      <= ~slowclock;
      end else begin
        count     <= count + 1'b1;
        tick      <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/slowclock_rate_controller.sv
// Run/pause/single-step FSM and rate register for the slow-clock divider.
// New rates are loaded only on entry or at a falling-edge boundary.
module slowclock_rate_controller
  import slowclock_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int HALF0 = DEF_HALF0,
  parameter int HALF1 = DEF_HALF1,
  parameter int HALF2 = DEF_HALF2,
  parameter int HALF3 = DEF_HALF3
) (
  input  logic                         clock,
  input  logic                         reset_n,
  slowclock_rate_controller_if.slave   bus
);

  sc_state_e        state_q;
  sc_state_e        state_d;
  logic [1:0]       rate_q;
  logic [1:0]       rate_d;
  logic [CNT_W-1:0] h;
  logic             active;
  logic             at_boundary;

  always_comb begin
    h = CNT_W'(HALF0);
    unique case (rate_q)
      2'd0:    h = CNT_W'(HALF0);
      2'd1:    h = CNT_W'(HALF1);
      2'd2:    h = CNT_W'(HALF2);
      2'd3:    h = CNT_W'(HALF3);
      default: h = CNT_W'(HALF0);
    endcase
  end

  assign active = (state_q == RUN) || (state_q == STEP);

  // step is only honoured from a stopped state; run always wins
  always_comb begin
    state_d = state_q;
    rate_d  = rate_q;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (bus.run) begin
          state_d = RUN;
          rate_d  = bus.rate_sel;
        end else if (bus.step) begin
          state_d = STEP;
          rate_d  = bus.rate_sel;
        end
      end
      RUN, STEP: begin
        if (at_boundary) begin
          if (bus.run) begin
            state_d = RUN;
            rate_d  = bus.rate_sel;
          end else begin
            state_d = PAUSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rate_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
    end
  end

  slowclock_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (active),
    .clear       (!active),
    .h           (h),
    .slowclock   (bus.slowclock),
    .tick        (bus.tick),
    .at_boundary (at_boundary)
  );

  assign bus.state       = state_q;
  assign bus.rate_active = rate_q;

endmodule

// File: tb/tb_slowclock_rate_controller.sv
// Bench for slowclock_rate_controller: directed scenarios plus random
// run/step/rate traffic against a period-phase reference model.
module tb_slowclock_rate_controller;
  import slowclock_pkg::*;

  localparam int H [4] = '{3, 1, 0, 7};

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  slowclock_rate_controller_if bus ();

  slowclock_rate_controller #(
    .CNT_W (DEF_CNT_W),
    .HALF0 (3),
    .HALF1 (1),
    .HALF2 (0),
    .HALF3 (7)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: mode 0..3, loaded rate, k = cycles since the period started
  int m_mode = 0;
  int m_rate = 0;
  int m_k    = 0;

  int cyc_no    = 0;
  int last_tick = -1;
  int period    = 0;
  int n_ticks   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc_no);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_rate = 0;
    m_k    = 0;
  endtask

  task automatic model_edge();
    if (m_mode < 2) begin
      if (bus.run) begin
        m_mode = 2;
        m_rate = int'(bus.rate_sel);
        m_k    = 0;
      end else if (bus.step) begin
        m_mode = 3;
        m_rate = int'(bus.rate_sel);
        m_k    = 0;
      end
    end else if (m_k == 2 * H[m_rate] + 1) begin
      if (bus.run) begin
        m_mode = 2;
        m_rate = int'(bus.rate_sel);
      end else begin
        m_mode = 1;
      end
      m_k = 0;
    end else begin
      m_k++;
    end
  endtask

  function automatic int exp_sc();
    if (m_mode < 2) return 0;
    return (m_k >= H[m_rate] + 1) ? 1 : 0;
  endfunction

  function automatic int exp_tick();
    if (m_mode < 2) return 0;
    return (m_k == H[m_rate] + 1) ? 1 : 0;
  endfunction

  task automatic compare_all();
    check("slowclock", bus.slowclock, exp_sc());
    check("tick", bus.tick, exp_tick());
    check("state", bus.state, m_mode);
    check("rate_active", bus.rate_active, m_rate);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
    cyc_no++;
    compare_all();
    if (bus.tick) begin
      n_ticks++;
      if (last_tick >= 0) period = cyc_no - last_tick;
      last_tick = cyc_no;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!bus.tick && n < 100);
    if (!bus.tick) check("wait_tick_timeout", 0, 1);
  endtask

  initial begin
    bus.run      = 1'b1;
    bus.step     = 1'b0;
    bus.rate_sel = 2'd0;
    model_reset();

    // 1: reset held with run=1, then release
    cycles(4);
    check("reset_state", bus.state, 0);
    @(negedge clock);
    reset_n   = 1'b1;
    last_tick = -1;
    cycle();
    check("run_after_reset", bus.state, 2);
    cycles(20);
    check("period_rate0", period, 8);

    // 2: rate change two cycles after a rising edge
    wait_tick();
    cycles(2);
    bus.rate_sel = 2'd1;
    cycles(20);
    check("period_rate1", period, 4);
    check("rate_now1", bus.rate_active, 1);

    // 3: pause one cycle after a rising edge
    wait_tick();
    cycle();
    bus.run = 1'b0;
    cycles(12);
    check("paused", bus.state, 1);
    n_ticks = 0;
    cycles(10);
    check("no_ticks_paused", n_ticks, 0);

    // 4: single step at rate 3, second pulse ignored
    bus.rate_sel = 2'd3;
    n_ticks      = 0;
    bus.step     = 1'b1;
    cycle();
    bus.step = 1'b0;
    check("stepping", bus.state, 3);
    cycles(5);
    bus.step = 1'b1;
    cycle();
    bus.step = 1'b0;
    cycles(30);
    check("one_step_tick", n_ticks, 1);
    check("step_done", bus.state, 1);

    // 5: HALF=0 and run beating step
    bus.rate_sel = 2'd2;
    bus.run      = 1'b1;
    bus.step     = 1'b1;
    cycle();
    bus.step = 1'b0;
    check("run_over_step", bus.state, 2);
    cycles(10);

    // 6: async reset mid-run at rate 0, slowclock=1, count=2
    bus.rate_sel = 2'd0;
    begin
      int n;
      n = 0;
      do begin
        wait_tick();
        n++;
      end while (bus.rate_active != 2'd0 && n < 10);
    end
    cycles(2);
    check("pre_reset_sc", bus.slowclock, 1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_sc", bus.slowclock, 0);
    check("async_tick", bus.tick, 0);
    check("async_state", bus.state, 0);
    check("async_rate", bus.rate_active, 0);
    @(negedge clock);
    bus.run = 1'b0;
    reset_n = 1'b1;
    cycles(3);
    check("idle_after_reset", bus.state, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0) bus.run = ~bus.run;
      bus.step = ($urandom_range(7) == 0);
      if ($urandom_range(7) == 0) bus.rate_sel = 2'($urandom_range(3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
